imem_load_arbiter: RTL and testbench
====================================

Name: imem_load_arbiter

Overview:
- Owns the single port of a synchronous instruction RAM (1-cycle read latency).
- Shares that port between the CPU fetch path and a streaming program loader.
- After reset, either streams a program into RAM from word 0 (holding the CPU in stall) or goes straight to run mode.
- In run mode it serves byte-addressed fetches, returning zero for out-of-range PCs.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction RAM (depth 2^ADDR_WIDTH words).
- DATA_WIDTH, 32, instruction and PC width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- boot_load  input  1  level request: enter or remain available for program load.
- ld_valid  input  1  loader word valid.
- ld_data  input  DATA_WIDTH  loader word.
- ld_last  input  1  final word of the program; qualified by an accepted beat.
- ld_ready  output  1  controller accepts a loader word this cycle.
- load_done  output  1  one-cycle pulse when a load completes.
- load_count  output  ADDR_WIDTH+1  number of words written in the current or most recent load.
- load_overflow  output  1  sticky: the load hit RAM depth before ld_last.
- fetch_en  input  1  CPU fetch request this cycle.
- pc_address  input  DATA_WIDTH  fetch byte address.
- instruction  output  DATA_WIDTH  fetched word; 0 when instr_valid=0.
- instr_valid  output  1  instruction is valid for the fetch accepted in the previous cycle.
- cpu_stall  output  1  CPU must hold the PC.
- mem_en  output  1  RAM port enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_WIDTH  RAM word address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- Reset values:
  - ld_ready=0, load_done=0, load_count=0, load_overflow=0.
  - instr_valid=0, instruction=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_stall=1.
- Memory-port outputs are combinational from state and inputs.
- instr_valid and the out-of-range flag are registered.
- IDLE: lasts exactly one cycle. boot_load=1 goes to LOAD (write pointer=0, load_count=0, load_overflow=0); otherwise goes to RUN. No memory access occurs in IDLE.
- LOAD:
  - ld_ready=1 and cpu_stall=1; fetch_en is ignored.
  - On a beat (ld_valid & ld_ready): mem_en=1, mem_we=1, mem_addr=ptr, mem_wdata=ld_data; ptr and load_count increment next edge.
  - With no beat: mem_en=0.
  - Beat with ld_last=1: write the word, go to RUN, load_done=1 for the following cycle only.
  - Beat at ptr=2^ADDR_WIDTH-1 with ld_last=0: write the word, set load_overflow, go to RUN, pulse load_done. Later loader words are not accepted because ld_ready=0.
  - boot_load deassertion during LOAD has no effect; only ld_last or overflow ends a load.
- RUN:
  - ld_ready=0. cpu_stall=boot_load (combinational).
  - Fetch when fetch_en=1 and boot_load=0.
    - In range (pc_address[DATA_WIDTH-1:ADDR_WIDTH+2]==0): mem_en=1, mem_we=0, mem_addr=pc_address[ADDR_WIDTH+1:2].
    - Out of range: mem_en=0.
  - Next cycle after a fetch: instr_valid=1. instruction=mem_rdata if in range, else 0.
  - Back-to-back fetches give one result per cycle, with 1-cycle latency.
  - pc_address[1:0] is ignored.
  - boot_load=1 in RUN: that cycle's fetch is suppressed; go to LOAD next edge with ptr, load_count and load_overflow cleared.
  - A fetch accepted in the last RUN cycle still returns instr_valid in the first LOAD cycle.
- load_count saturates at 2^ADDR_WIDTH and holds its value after a load until the next LOAD entry.
- Reset mid-load: the FSM returns to IDLE and all counters and flags clear. RAM contents are not modified.
- At most one RAM access per cycle; mem_we=1 only in LOAD.

Test Plan:
- rst high 2 cycles, boot_load=0 -> cpu_stall=1 through IDLE, then RUN. Fetch pc=0x8 returns instr_valid=1 with RAM word 2 one cycle later. mem_we is never 1.
- boot_load=1 at reset release, loader streams 0x00500093, 0x00A00113, 0x002081B3 (last on 3rd), with ld_valid gaps -> writes to words 0..2 only on beats. load_count=3, load_done one pulse, then RUN. Fetches at 0x0/0x4/0x8 return the same 3 words back-to-back.
- RUN fetch pc=0x00000400 (ADDR_WIDTH=8) -> mem_en=0, next cycle instr_valid=1, instruction=0x00000000.
- Load 256 words without ld_last -> all 256 written, load_overflow=1, load_count=256, ld_ready=0 afterward. A 257th ld_valid is not accepted.
- In RUN, assert fetch_en and boot_load in the same cycle -> no RAM read that cycle, cpu_stall=1, LOAD next cycle. Reload of 2 words overwrites words 0..1; word 2 retains its old value when fetched.
- Assert rst after 5 of 10 load words -> IDLE next cycle, load_count=0, ld_ready=0. Words 0..4 retain the written data.

Source files
------------

// File: rtl/imem_load_arbiter.sv
// Single-port instruction RAM arbiter: streams a boot program into RAM, then
// serves CPU fetches with 1-cycle latency and zero for out-of-range PCs.
module imem_load_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_load,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_overflow,
  input  logic                  fetch_en,
  input  logic [DATA_WIDTH-1:0] pc_address,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  cpu_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  oor_q;
  logic                  beat;
  logic                  fetch;
  logic                  in_range;
  logic                  unused_pc_bits;

  // Byte offset within a word carries no information for word fetches.
  assign unused_pc_bits = ^pc_address[1:0];

  assign in_range  = (pc_address[DATA_WIDTH-1:ADDR_WIDTH+2] == '0);
  assign beat      = (state == LOAD) && ld_valid && !rst;
  assign fetch     = (state == RUN) && fetch_en && !boot_load && !rst;
  assign ld_ready  = (state == LOAD) && !rst;
  assign cpu_stall = rst || (state != RUN) || boot_load;
  assign instruction = (instr_valid && !oor_q) ? mem_rdata : '0;

  // RAM port mux: loader write beats in LOAD, in-range reads in RUN.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (beat) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ptr;
      mem_wdata = ld_data;
    end else if (fetch && in_range) begin
      mem_en   = 1'b1;
      mem_addr = pc_address[ADDR_WIDTH+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      load_count    <= '0;
      load_overflow <= 1'b0;
      load_done     <= 1'b0;
      instr_valid   <= 1'b0;
      oor_q         <= 1'b0;
    end else begin
      load_done   <= 1'b0;
      instr_valid <= fetch;
      oor_q       <= fetch && !in_range;
      case (state)
        IDLE: begin
          if (boot_load) begin
            state         <= LOAD;
            ptr           <= '0;
            load_count    <= '0;
            load_overflow <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (beat) begin
            ptr <= ptr + ADDR_WIDTH'(1);
            if (load_count != DEPTH) load_count <= load_count + CNT_W'(1);
            // Last word or final RAM slot both end the load.
            if (ld_last) begin
              state     <= RUN;
              load_done <= 1'b1;
            end else if (ptr == PTR_MAX) begin
              state         <= RUN;
              load_done     <= 1'b1;
              load_overflow <= 1'b1;
            end
          end
        end
        RUN: begin
          if (boot_load) begin
            state         <= LOAD;
            ptr           <= '0;
            load_count    <= '0;
            load_overflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a behavioural 1-cycle RAM.
module tb_imem_load_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_load;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          load_done;
  logic [AW:0]   load_count;
  logic          load_overflow;
  logic          fetch_en;
  logic [DW-1:0] pc_address;
  logic [DW-1:0] instruction;
  logic          instr_valid;
  logic          cpu_stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] prog [0:2];

  int checks = 0;
  int errors = 0;

  imem_load_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .boot_load(boot_load),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .load_done(load_done), .load_count(load_count), .load_overflow(load_overflow),
    .fetch_en(fetch_en), .pc_address(pc_address), .instruction(instruction),
    .instr_valid(instr_valid), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hA000_0000 + DW'(i);
    mem_rdata = '0;
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    rst = 1'b1; boot_load = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    fetch_en = 1'b0; pc_address = '0;
    tick(); tick();

    // Reset values
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_load_count", 64'(load_count), 64'd0);
    chk("rst_overflow", 64'(load_overflow), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instruction", 64'(instruction), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd1);

    // Plain boot straight to RUN
    rst = 1'b0; #1;
    chk("idle_stall", 64'(cpu_stall), 64'd1);
    chk("idle_mem_en", 64'(mem_en), 64'd0);
    tick();
    fetch_en = 1'b1; pc_address = 32'h8; #1;
    chk("run_stall", 64'(cpu_stall), 64'd0);
    chk("fetch8_mem_en", 64'(mem_en), 64'd1);
    chk("fetch8_mem_we", 64'(mem_we), 64'd0);
    chk("fetch8_addr", 64'(mem_addr), 64'd2);
    tick();
    fetch_en = 1'b0;
    chk("fetch8_valid", 64'(instr_valid), 64'd1);
    chk("fetch8_data", 64'(instruction), 64'hA000_0002);
    tick();
    chk("idle_fetch_valid", 64'(instr_valid), 64'd0);
    chk("idle_fetch_data", 64'(instruction), 64'd0);

    // Boot load of 3 words with valid gaps
    rst = 1'b1; tick();
    rst = 1'b0; boot_load = 1'b1; #1;
    chk("idle_ld_ready", 64'(ld_ready), 64'd0);
    tick();
    boot_load = 1'b0;
    chk("load_ld_ready", 64'(ld_ready), 64'd1);
    chk("load_stall", 64'(cpu_stall), 64'd1);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b0; fetch_en = 1'b1; pc_address = 32'h8; #1;
      chk("gap_mem_en", 64'(mem_en), 64'd0);
      tick();
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 2); #1;
      chk("beat_we", 64'(mem_we), 64'd1);
      chk("beat_addr", 64'(mem_addr), 64'(i));
      chk("beat_wdata", 64'(mem_wdata), 64'(prog[i]));
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
    chk("load3_done", 64'(load_done), 64'd1);
    chk("load3_count", 64'(load_count), 64'd3);
    chk("load3_ready", 64'(ld_ready), 64'd0);
    chk("load3_ram3", 64'(ram[3]), 64'hA000_0003);
    tick();
    chk("load3_done_pulse", 64'(load_done), 64'd0);

    // Back-to-back fetches of the loaded program
    for (int i = 0; i < 3; i++) begin
      fetch_en = 1'b1; pc_address = DW'(4 * i); #1;
      chk("b2b_addr", 64'(mem_addr), 64'(i));
      tick();
      chk("b2b_valid", 64'(instr_valid), 64'd1);
      chk("b2b_data", 64'(instruction), 64'(prog[i]));
    end

    // Out-of-range PC returns zero
    pc_address = 32'h0000_0400; #1;
    chk("oor_mem_en", 64'(mem_en), 64'd0);
    tick();
    fetch_en = 1'b0;
    chk("oor_valid", 64'(instr_valid), 64'd1);
    chk("oor_data", 64'(instruction), 64'd0);

    // Fetch then fetch+boot_load collision, reload 2 words
    fetch_en = 1'b1; pc_address = 32'h4; tick();
    boot_load = 1'b1; pc_address = 32'h8; #1;
    chk("coll_valid", 64'(instr_valid), 64'd1);
    chk("coll_data", 64'(instruction), 64'(prog[1]));
    chk("coll_mem_en", 64'(mem_en), 64'd0);
    chk("coll_stall", 64'(cpu_stall), 64'd1);
    tick();
    boot_load = 1'b0; fetch_en = 1'b0;
    chk("coll_ld_ready", 64'(ld_ready), 64'd1);
    chk("coll_count", 64'(load_count), 64'd0);
    chk("coll_no_valid", 64'(instr_valid), 64'd0);
    ld_valid = 1'b1; ld_data = 32'h1111_1111; tick();
    ld_data = 32'h2222_2222; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("reload_count", 64'(load_count), 64'd2);
    chk("reload_done", 64'(load_done), 64'd1);
    for (int i = 0; i < 3; i++) begin
      fetch_en = 1'b1; pc_address = DW'(4 * i); tick();
      case (i)
        0: chk("reload_w0", 64'(instruction), 64'h1111_1111);
        1: chk("reload_w1", 64'(instruction), 64'h2222_2222);
        default: chk("reload_w2", 64'(instruction), 64'(prog[2]));
      endcase
    end
    fetch_en = 1'b0;

    // Overflow: 256 words without ld_last
    boot_load = 1'b1; tick();
    boot_load = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      ld_valid = 1'b1; ld_data = 32'hB000_0000 + DW'(i); #1;
      if (i == (1 << AW) - 1) chk("ovf_last_addr", 64'(mem_addr), 64'd255);
      tick();
    end
    chk("ovf_flag", 64'(load_overflow), 64'd1);
    chk("ovf_count", 64'(load_count), 64'd256);
    chk("ovf_done", 64'(load_done), 64'd1);
    chk("ovf_ready", 64'(ld_ready), 64'd0);
    ld_data = 32'hDEAD_BEEF;
    chk("ovf_257_mem_en", 64'(mem_en), 64'd0);
    tick();
    ld_valid = 1'b0;
    chk("ovf_count_hold", 64'(load_count), 64'd256);
    chk("ovf_ram0", 64'(ram[0]), 64'hB000_0000);
    chk("ovf_ram255", 64'(ram[255]), 64'hB000_00FF);

    // Reset after 5 of 10 words
    boot_load = 1'b1; tick();
    boot_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 32'hC000_0000 + DW'(i); tick();
    end
    rst = 1'b1; ld_data = 32'hFFFF_FFFF; #1;
    chk("rstmid_mem_en", 64'(mem_en), 64'd0);
    tick();
    ld_valid = 1'b0;
    chk("rstmid_count", 64'(load_count), 64'd0);
    chk("rstmid_ready", 64'(ld_ready), 64'd0);
    chk("rstmid_ovf", 64'(load_overflow), 64'd0);
    for (int i = 0; i < 5; i++) chk("rstmid_ram", 64'(ram[i]), 64'(32'hC000_0000 + DW'(i)));
    chk("rstmid_ram5", 64'(ram[5]), 64'hB000_0005);
    rst = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
